// File: rtl/rf_pkg.sv
// Register-file bank read arbiter: shared constants and the per-bank request entry.
// Contents: bank/row/slot/data widths, FIFO sizing, rf_req_t {row, ocid, dup}.
package rf_pkg;

    localparam int unsigned NBANK      = 4;
    localparam int unsigned NROW       = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned BANK_W     = 2;
    localparam int unsigned ROW_W      = 3;
    localparam int unsigned OCID_W     = 3;
    localparam int unsigned DW         = 256;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    // One queued read: row to read, destination OC slot, deliver-to-pair flag.
    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [OCID_W-1:0] ocid;
        logic              dup;
    } rf_req_t;

endpackage

// File: rtl/rf_bank_read_arbiter_if.sv
// Register-file bank read arbiter bus: operand read request bundle with stall,
// CDB write port and the per-bank read return path.
// master: requester / CDB / operand collector side; slave: the arbiter.
interface rf_bank_read_arbiter_if;
    import rf_pkg::*;

    logic                      Valid_RAU_RF;
    logic                      Src1_Valid;
    logic                      Src2_Valid;
    logic [BANK_W-1:0]         Src1_Phy_Bank_ID;
    logic [BANK_W-1:0]         Src2_Phy_Bank_ID;
    logic [ROW_W-1:0]          Src1_Phy_Row_ID;
    logic [ROW_W-1:0]          Src2_Phy_Row_ID;
    logic [OCID_W-1:0]         Src1_OCID_RAU_OC;
    logic [OCID_W-1:0]         Src2_OCID_RAU_OC;
    logic                      ReqFIFO_2op_EN;
    logic                      ReqFIFO_Same;
    logic                      ReqStall_RF_RAU;
    logic                      WriteEn_CDB_RF;
    logic [BANK_W-1:0]         WriteBank;
    logic [ROW_W-1:0]          WriteRow;
    logic [DW-1:0]             Data_CDB;
    logic [NBANK-1:0]          RdValid_RF_OC;
    logic [NBANK*OCID_W-1:0]   RdOCID_RF_OC;
    logic [NBANK-1:0]          RdDup_RF_OC;
    logic [NBANK*DW-1:0]       RdData_RF_OC;

    modport master (
        output Valid_RAU_RF, Src1_Valid, Src2_Valid, Src1_Phy_Bank_ID, Src2_Phy_Bank_ID,
               Src1_Phy_Row_ID, Src2_Phy_Row_ID, Src1_OCID_RAU_OC, Src2_OCID_RAU_OC,
               ReqFIFO_2op_EN, ReqFIFO_Same, WriteEn_CDB_RF, WriteBank, WriteRow, Data_CDB,
        input  ReqStall_RF_RAU, RdValid_RF_OC, RdOCID_RF_OC, RdDup_RF_OC, RdData_RF_OC
    );

    modport slave (
        input  Valid_RAU_RF, Src1_Valid, Src2_Valid, Src1_Phy_Bank_ID, Src2_Phy_Bank_ID,
               Src1_Phy_Row_ID, Src2_Phy_Row_ID, Src1_OCID_RAU_OC, Src2_OCID_RAU_OC,
               ReqFIFO_2op_EN, ReqFIFO_Same, WriteEn_CDB_RF, WriteBank, WriteRow, Data_CDB,
        output ReqStall_RF_RAU, RdValid_RF_OC, RdOCID_RF_OC, RdDup_RF_OC, RdData_RF_OC
    );

endinterface

// File: rtl/rf_req_fifo.sv
// Per-bank read request FIFO: up to two pushes per cycle (push0 then push1), one pop.
// Ports: clk, rst (sync active-low), push0/push1 + din0/din1, pop,
//        count (0..FIFO_DEPTH), empty, head (entry at the read pointer).
module rf_req_fifo
    import rf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push0,
    input  logic             push1,
    input  rf_req_t          din0,
    input  rf_req_t          din1,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output rf_req_t          head
);

    rf_req_t          mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    rf_req_t          first;
    logic [CNT_W-1:0] n_push;

    // A lone push1 still lands in the first free slot.
    always_comb begin
        first  = push0 ? din0 : din1;
        n_push = CNT_W'(push0) + CNT_W'(push1);
    end

    // Entry storage, not reset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push0 || push1) mem[wr_ptr] <= first;
        if (push0 && push1) mem[wr_ptr + PTR_W'(1)] <= din1;
    end

    // Pointers wrap modulo FIFO_DEPTH; count carries the extra full bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + n_push - CNT_W'(pop);
        end
    end

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/rf_bank_read_arbiter.sv
// Register-file bank read arbiter: decodes operand read bundles into per-bank FIFOs,
// gives each bank's single port to a CDB write when present, otherwise pops a queued
// read, and returns registered 256-bit data tagged with the OC slot.
// Ports: clk, rst (sync active-low), bus (rf_bank_read_arbiter_if.slave).
module rf_bank_read_arbiter
    import rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    rf_bank_read_arbiter_if.slave bus
);

    rf_req_t          e1;
    rf_req_t          e2;
    logic [NBANK-1:0] want0;
    logic [NBANK-1:0] want1;
    rf_req_t          din0 [NBANK];
    rf_req_t          din1 [NBANK];
    logic [NBANK-1:0] over;
    logic             stall;
    logic             accept;
    logic [CNT_W-1:0] count [NBANK];
    logic [NBANK-1:0] empty;
    rf_req_t          head  [NBANK];
    logic [NBANK-1:0] wr_hit;
    logic [NBANK-1:0] pop;

    // Bundle decode into at most two ordered entries per bank.
    always_comb begin
        e1    = '{row: bus.Src1_Phy_Row_ID, ocid: bus.Src1_OCID_RAU_OC, dup: 1'b0};
        e2    = '{row: bus.Src2_Phy_Row_ID, ocid: bus.Src2_OCID_RAU_OC, dup: 1'b0};
        want0 = '0;
        want1 = '0;
        for (int b = 0; b < NBANK; b++) begin
            din0[b] = e2;
            din1[b] = e2;
        end
        if (bus.ReqFIFO_Same) begin
            want0[bus.Src1_Phy_Bank_ID] = 1'b1;
            din0[bus.Src1_Phy_Bank_ID]  = '{row: bus.Src1_Phy_Row_ID,
                                            ocid: bus.Src1_OCID_RAU_OC, dup: 1'b1};
        end else if (bus.ReqFIFO_2op_EN) begin
            want0[bus.Src1_Phy_Bank_ID] = 1'b1;
            want1[bus.Src1_Phy_Bank_ID] = 1'b1;
            din0[bus.Src1_Phy_Bank_ID]  = e1;
        end else begin
            if (bus.Src1_Valid) begin
                want0[bus.Src1_Phy_Bank_ID] = 1'b1;
                din0[bus.Src1_Phy_Bank_ID]  = e1;
            end
            if (bus.Src2_Valid) begin
                if (bus.Src1_Valid && (bus.Src1_Phy_Bank_ID == bus.Src2_Phy_Bank_ID))
                    want1[bus.Src2_Phy_Bank_ID] = 1'b1;
                else
                    want0[bus.Src2_Phy_Bank_ID] = 1'b1;
            end
        end
    end

    // Stall on registered occupancy only, so the bundle is accepted whole or not at all.
    always_comb begin
        over = '0;
        for (int b = 0; b < NBANK; b++)
            over[b] = (32'(count[b]) + 32'(want0[b]) + 32'(want1[b])) > FIFO_DEPTH;
    end

    assign stall               = bus.Valid_RAU_RF && (over != '0);
    assign accept              = bus.Valid_RAU_RF && !stall;
    assign bus.ReqStall_RF_RAU = stall;

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [DW-1:0]     mem [NROW];
        logic              rd_valid;
        logic [OCID_W-1:0] rd_ocid;
        logic              rd_dup;
        logic [DW-1:0]     rd_data;

        rf_req_fifo u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push0 (accept && want0[b]),
            .push1 (accept && want1[b]),
            .din0  (din0[b]),
            .din1  (din1[b]),
            .pop   (pop[b]),
            .count (count[b]),
            .empty (empty[b]),
            .head  (head[b])
        );

        // The CDB write owns the port; a read waits, so no bypass is ever needed.
        assign wr_hit[b] = bus.WriteEn_CDB_RF && (bus.WriteBank == BANK_W'(b));
        assign pop[b]    = !wr_hit[b] && !empty[b];

        always_ff @(posedge clk) begin
            if (wr_hit[b]) mem[bus.WriteRow] <= bus.Data_CDB;
        end

        // Return registers: tag and data hold between pops.
        always_ff @(posedge clk) begin
            if (!rst) begin
                rd_valid <= 1'b0;
                rd_ocid  <= '0;
                rd_dup   <= 1'b0;
                rd_data  <= '0;
            end else begin
                rd_valid <= pop[b];
                if (pop[b]) begin
                    rd_ocid <= head[b].ocid;
                    rd_dup  <= head[b].dup;
                    rd_data <= mem[head[b].row];
                end
            end
        end

        assign bus.RdValid_RF_OC[b]                   = rd_valid;
        assign bus.RdOCID_RF_OC[b*OCID_W +: OCID_W]   = rd_ocid;
        assign bus.RdDup_RF_OC[b]                     = rd_dup;
        assign bus.RdData_RF_OC[b*DW +: DW]           = rd_data;
    end

endmodule

// File: tb/tb_rf_bank_read_arbiter.sv
// Directed bench for rf_bank_read_arbiter: inputs change and outputs are sampled
// on the falling edge, away from the rising edge that clocks the design.
module tb_rf_bank_read_arbiter;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rf_bank_read_arbiter_if bus ();

    rf_bank_read_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [255:0] PA5 = {32{8'hA5}};
    localparam logic [255:0] P0  = {8{32'h1111_0000}};
    localparam logic [255:0] P3  = {8{32'h3333_0003}};
    localparam logic [255:0] P7  = {8{32'h7777_0007}};
    localparam logic [255:0] W1  = {8{32'hC0DE_0001}};
    localparam logic [255:0] W2  = {8{32'hC0DE_0002}};
    localparam logic [255:0] W3  = {8{32'hC0DE_0003}};
    localparam logic [255:0] JNK = {8{32'hDEAD_BEEF}};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_req();
        bus.Valid_RAU_RF     = 1'b0;
        bus.Src1_Valid       = 1'b0;
        bus.Src2_Valid       = 1'b0;
        bus.Src1_Phy_Bank_ID = '0;
        bus.Src2_Phy_Bank_ID = '0;
        bus.Src1_Phy_Row_ID  = '0;
        bus.Src2_Phy_Row_ID  = '0;
        bus.Src1_OCID_RAU_OC = '0;
        bus.Src2_OCID_RAU_OC = '0;
        bus.ReqFIFO_2op_EN   = 1'b0;
        bus.ReqFIFO_Same     = 1'b0;
    endtask

    task automatic req(input logic v1, input logic [1:0] b1, input logic [2:0] r1,
                       input logic [2:0] o1, input logic v2, input logic [1:0] b2,
                       input logic [2:0] r2, input logic [2:0] o2,
                       input logic two, input logic same);
        bus.Valid_RAU_RF     = 1'b1;
        bus.Src1_Valid       = v1;
        bus.Src2_Valid       = v2;
        bus.Src1_Phy_Bank_ID = b1;
        bus.Src2_Phy_Bank_ID = b2;
        bus.Src1_Phy_Row_ID  = r1;
        bus.Src2_Phy_Row_ID  = r2;
        bus.Src1_OCID_RAU_OC = o1;
        bus.Src2_OCID_RAU_OC = o2;
        bus.ReqFIFO_2op_EN   = two;
        bus.ReqFIFO_Same     = same;
    endtask

    task automatic cdb(input logic en, input logic [1:0] bank, input logic [2:0] row,
                       input logic [255:0] data);
        bus.WriteEn_CDB_RF = en;
        bus.WriteBank      = bank;
        bus.WriteRow       = row;
        bus.Data_CDB       = data;
    endtask

    // Checks one bank's return: valid vector, slot tag, dup flag and data.
    task automatic chk_ret(input string tag, input logic [3:0] vld, input int b,
                           input logic [2:0] ocid, input logic dup, input logic [255:0] data);
        chk({tag, ".valid"}, 256'(bus.RdValid_RF_OC), 256'(vld));
        chk({tag, ".ocid"}, 256'(bus.RdOCID_RF_OC[b*3 +: 3]), 256'(ocid));
        chk({tag, ".dup"}, 256'(bus.RdDup_RF_OC[b]), 256'(dup));
        chk({tag, ".data"}, bus.RdData_RF_OC[b*256 +: 256], data);
    endtask

    task automatic chk_none(input string tag);
        chk({tag, ".valid"}, 256'(bus.RdValid_RF_OC), 256'(4'b0000));
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        #1;
        chk({tag, ".stall"}, 256'(bus.ReqStall_RF_RAU), 256'(exp));
    endtask

    initial begin
        rst = 1'b0;
        idle_req();
        cdb(1'b0, 2'd0, 3'd0, '0);

        // Reset state
        tick();
        tick();
        chk_none("rst");
        chk("rst.ocid", 256'(bus.RdOCID_RF_OC), 256'(12'h000));
        chk("rst.dup", 256'(bus.RdDup_RF_OC), 256'(4'b0000));
        for (int b = 0; b < 4; b++) chk("rst.data", bus.RdData_RF_OC[b*256 +: 256], '0);
        chk_stall("rst", 1'b0);
        rst = 1'b1;
        tick();

        // Single read, bank 2 row 5, slot 4
        cdb(1'b1, 2'd2, 3'd5, PA5);
        tick();
        cdb(1'b0, 2'd0, 3'd0, '0);
        req(1'b1, 2'd2, 3'd5, 3'd4, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        chk_stall("t1", 1'b0);
        tick();
        idle_req();
        chk_none("t1.lat1");
        tick();
        chk_ret("t1", 4'b0100, 2, 3'd4, 1'b0, PA5);
        tick();
        chk_none("t1.after");

        // Two operands, same bank: Src1 entry returns first
        cdb(1'b1, 2'd1, 3'd0, P0);
        tick();
        cdb(1'b1, 2'd1, 3'd3, P3);
        tick();
        cdb(1'b0, 2'd0, 3'd0, '0);
        req(1'b1, 2'd1, 3'd0, 3'd2, 1'b1, 2'd1, 3'd3, 3'd3, 1'b1, 1'b0);
        tick();
        idle_req();
        tick();
        chk_ret("t2.a", 4'b0010, 1, 3'd2, 1'b0, P0);
        tick();
        chk_ret("t2.b", 4'b0010, 1, 3'd3, 1'b0, P3);
        tick();
        chk_none("t2.after");

        // Same register: single return with dup
        cdb(1'b1, 2'd0, 3'd7, P7);
        tick();
        cdb(1'b0, 2'd0, 3'd0, '0);
        req(1'b1, 2'd0, 3'd7, 3'd6, 1'b1, 2'd0, 3'd7, 3'd6, 1'b1, 1'b1);
        tick();
        idle_req();
        tick();
        chk_ret("t3", 4'b0001, 0, 3'd6, 1'b1, P7);
        tick();
        chk_none("t3.after");

        // CDB writes hold off a bank-3 read; bank 1 proceeds independently
        req(1'b1, 2'd3, 3'd2, 3'd5, 1'b1, 2'd1, 3'd0, 3'd1, 1'b0, 1'b0);
        cdb(1'b1, 2'd3, 3'd2, W1);
        chk_stall("t4", 1'b0);
        tick();
        idle_req();
        cdb(1'b1, 2'd3, 3'd2, W2);
        chk_none("t4.w1");
        tick();
        chk_ret("t4.bank1", 4'b0010, 1, 3'd1, 1'b0, P0);
        cdb(1'b1, 2'd3, 3'd2, W3);
        tick();
        chk_none("t4.w3");
        cdb(1'b0, 2'd0, 3'd0, '0);
        tick();
        chk_ret("t4.bank3", 4'b1000, 3, 3'd5, 1'b0, W3);
        tick();
        chk_none("t4.after");

        // Stall: bank 0 holds 3 entries, 2-entry bundle must wait for one pop
        cdb(1'b1, 2'd0, 3'd6, JNK);
        req(1'b1, 2'd0, 3'd7, 3'd0, 1'b1, 2'd0, 3'd7, 3'd1, 1'b1, 1'b0);
        chk_stall("t5.fill2", 1'b0);
        tick();
        req(1'b1, 2'd0, 3'd7, 3'd2, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        chk_stall("t5.fill3", 1'b0);
        tick();
        req(1'b1, 2'd0, 3'd7, 3'd3, 1'b1, 2'd0, 3'd7, 3'd4, 1'b1, 1'b0);
        chk_stall("t5.full", 1'b1);
        tick();
        chk_none("t5.held");
        cdb(1'b0, 2'd0, 3'd0, '0);
        chk_stall("t5.held", 1'b1);
        tick();
        chk_ret("t5.r0", 4'b0001, 0, 3'd0, 1'b0, P7);
        chk_stall("t5.accept", 1'b0);
        tick();
        idle_req();
        chk_ret("t5.r1", 4'b0001, 0, 3'd1, 1'b0, P7);
        chk_stall("t5.idle", 1'b0);
        tick();
        chk_ret("t5.r2", 4'b0001, 0, 3'd2, 1'b0, P7);
        tick();
        chk_ret("t5.r3", 4'b0001, 0, 3'd3, 1'b0, P7);
        tick();
        chk_ret("t5.r4", 4'b0001, 0, 3'd4, 1'b0, P7);
        tick();
        chk_none("t5.after");

        // Reset with bank 2 full: queue dropped, no stale returns
        cdb(1'b1, 2'd2, 3'd0, JNK);
        req(1'b1, 2'd2, 3'd5, 3'd0, 1'b1, 2'd2, 3'd5, 3'd1, 1'b1, 1'b0);
        tick();
        req(1'b1, 2'd2, 3'd5, 3'd2, 1'b1, 2'd2, 3'd5, 3'd3, 1'b1, 1'b0);
        chk_stall("t6.fill4", 1'b0);
        tick();
        req(1'b1, 2'd2, 3'd5, 3'd7, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        chk_stall("t6.full", 1'b1);
        idle_req();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        cdb(1'b0, 2'd0, 3'd0, '0);
        chk_none("t6.rst");
        chk("t6.rst.data", bus.RdData_RF_OC[2*256 +: 256], '0);
        chk_stall("t6.rst.idle", 1'b0);
        req(1'b1, 2'd2, 3'd5, 3'd7, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        chk_stall("t6.empty", 1'b0);
        tick();
        idle_req();
        chk_none("t6.nostale");
        tick();
        chk_ret("t6.fresh", 4'b0100, 2, 3'd7, 1'b0, PA5);
        tick();
        chk_none("t6.after1");
        tick();
        chk_none("t6.after2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
